// File: rtl/serial_reader_10bit.sv
// serial_reader_10bit: accepts a parallel word over a valid/ready handshake and
// shifts it out LSB first on a one-wire link, holding each bit for
// CLKS_PER_BIT cycles, then pulses done for one cycle.
module serial_reader_10bit #(
  parameter int WIDTH        = 10,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CLK_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CLK_W-1:0] clk_cnt_q, clk_cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Ready only when idle, enabled and out of reset; purely combinational.
  assign din_ready  = (state_q == S_IDLE) & en & reset;

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Next-state and next-output logic; with en low every register holds,
  // which also keeps a pending done pulse alive until en returns.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    clk_cnt_d    = clk_cnt_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    busy_d       = busy_q;
    done_d       = done_q;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          sout_d       = 1'b1;
          sout_valid_d = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b0;
          if (din_valid) begin
            // Word captured here only; the first bit appears next cycle.
            state_d      = S_SHIFT;
            shreg_d      = din;
            bit_cnt_d    = '0;
            clk_cnt_d    = '0;
            sout_d       = din[0];
            sout_valid_d = 1'b1;
            busy_d       = 1'b1;
          end
        end
        S_SHIFT: begin
          if (clk_cnt_q == CLK_LAST) begin
            clk_cnt_d = '0;
            shreg_d   = shreg_q >> 1;
            if (bit_cnt_q == BIT_LAST) begin
              // Last bit finished: bit_cnt stays at its terminal value.
              state_d      = S_DONE;
              done_d       = 1'b1;
              sout_d       = 1'b1;
              sout_valid_d = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              sout_d    = shreg_q[1];
            end
          end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d      = S_IDLE;
          done_d       = 1'b0;
          busy_d       = 1'b0;
          sout_d       = 1'b1;
          sout_valid_d = 1'b0;
        end
        default: begin
          state_d      = S_IDLE;
          done_d       = 1'b0;
          busy_d       = 1'b0;
          sout_d       = 1'b1;
          sout_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      clk_cnt_q    <= '0;
      sout_q       <= 1'b1;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      clk_cnt_q    <= clk_cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

endmodule
